// File: rtl/ht16d35a_cmd_sequencer_if.sv
// Handshake/bus bundle between the HT16D35A command sequencer, the SPI
// controller it feeds and the host that issues display-RAM writes.
//   spi_activate/spi_in_cs/spi_out_data/spi_out_count : sequencer -> controller
//   spi_busy                                          : controller -> sequencer
//   req_valid/req_cs/req_addr/req_data/req_len        : host -> sequencer
//   req_ready                                         : sequencer -> host
// Modports: master = sequencer side, slave = controller/host side.
interface ht16d35a_cmd_sequencer_if #(
    parameter int NUM_SELECTS  = 2,
    parameter int OUT_BYTES    = 8,
    parameter int OUT_BYTES_SZ = $clog2(OUT_BYTES)
);
    logic                          spi_activate;
    logic [NUM_SELECTS-1:0]        spi_in_cs;
    logic [OUT_BYTES-1:0][7:0]     spi_out_data;
    logic [OUT_BYTES_SZ-1:0]       spi_out_count;
    logic                          spi_busy;
    logic                          req_valid;
    logic                          req_ready;
    logic [NUM_SELECTS-1:0]        req_cs;
    logic [7:0]                    req_addr;
    logic [OUT_BYTES-3:0][7:0]     req_data;
    logic [OUT_BYTES_SZ-1:0]       req_len;

    modport master (
        output spi_activate, spi_in_cs, spi_out_data, spi_out_count, req_ready,
        input  spi_busy, req_valid, req_cs, req_addr, req_data, req_len
    );

    modport slave (
        input  spi_activate, spi_in_cs, spi_out_data, spi_out_count, req_ready,
        output spi_busy, req_valid, req_cs, req_addr, req_data, req_len
    );
endinterface

// File: rtl/ht16d35a_cmd_sequencer.sv
// Command source for the HT16D35A SPI controller. After reset it waits out the
// driver power-up time, broadcasts the init sequence (soft reset, oscillator +
// display on, global brightness) and then turns each host write request into
// one SPI transaction {0x80, addr, payload...}.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus (master)  : controller handshake (activate/busy, cs, byte buffer, count)
//                   and host request channel (valid/ready, cs, addr, data, len)
//   init_done     : init sequence finished, requests are accepted
//   error         : sticky, set on an accept timeout or an illegal req_len
module ht16d35a_cmd_sequencer #(
    parameter int         NUM_SELECTS  = 2,
    parameter int         OUT_BYTES    = 8,
    parameter int         OUT_BYTES_SZ = $clog2(OUT_BYTES),
    parameter int         CLK_POWERUP  = 500000,
    parameter int         CLK_SWRESET  = 50000,
    parameter logic [7:0] BRIGHTNESS   = 8'h40,
    parameter int         ACCEPT_TMO   = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    ht16d35a_cmd_sequencer_if.master  bus,
    output logic                      init_done,
    output logic                      error
);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_LAUNCH,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_DELAY,
        S_READY
    } state_t;

    state_t                    state;
    logic [31:0]               cnt;
    logic [1:0]                idx;
    logic                      in_init;
    logic [NUM_SELECTS-1:0]    lat_cs;
    logic [OUT_BYTES-1:0][7:0] lat_bytes;
    logic [OUT_BYTES_SZ-1:0]   lat_count;

    logic [OUT_BYTES-1:0][7:0] init_bytes;
    logic [OUT_BYTES_SZ-1:0]   init_count;
    logic [OUT_BYTES-1:0][7:0] req_bytes;
    logic                      len_ok;

    always_comb begin
        bus.req_ready = (state == S_READY);
    end

    // Init table, indexed by idx.
    always_comb begin
        init_bytes = '0;
        init_count = '0;
        case (idx)
            2'd0: begin
                init_bytes[0] = 8'hCC;
            end
            2'd1: begin
                init_bytes[0] = 8'h35;
                init_bytes[1] = 8'h03;
                init_count    = OUT_BYTES_SZ'(1);
            end
            default: begin
                init_bytes[0] = 8'h37;
                init_bytes[1] = BRIGHTNESS;
                init_count    = OUT_BYTES_SZ'(1);
            end
        endcase
    end

    // Request frame: write command, start address, then req_len payload bytes.
    always_comb begin
        req_bytes    = '0;
        req_bytes[0] = 8'h80;
        req_bytes[1] = bus.req_addr;
        for (int unsigned i = 0; i < unsigned'(OUT_BYTES - 2); i++) begin
            if (i < 32'(bus.req_len)) begin
                req_bytes[i + 2] = bus.req_data[i];
            end
        end
        len_ok = (bus.req_len != '0) && (32'(bus.req_len) <= 32'(OUT_BYTES - 2));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_POWERUP;
            cnt               <= '0;
            idx               <= '0;
            in_init           <= 1'b1;
            lat_cs            <= '0;
            lat_bytes         <= '0;
            lat_count         <= '0;
            bus.spi_activate  <= 1'b0;
            bus.spi_in_cs     <= '0;
            bus.spi_out_data  <= '0;
            bus.spi_out_count <= '0;
            init_done         <= 1'b0;
            error             <= 1'b0;
        end else begin
            case (state)
                S_POWERUP: begin
                    // Controller holds busy high while it is itself in reset.
                    if (cnt < 32'(CLK_POWERUP - 1)) begin
                        cnt <= cnt + 32'd1;
                    end else if (!bus.spi_busy) begin
                        state   <= S_LOAD;
                        idx     <= '0;
                        in_init <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_init) begin
                        bus.spi_in_cs     <= '1;
                        bus.spi_out_data  <= init_bytes;
                        bus.spi_out_count <= init_count;
                    end else begin
                        bus.spi_in_cs     <= lat_cs;
                        bus.spi_out_data  <= lat_bytes;
                        bus.spi_out_count <= lat_count;
                    end
                    // Activate is registered here so it is high exactly while
                    // the state is S_LAUNCH / S_WAIT_ACCEPT.
                    bus.spi_activate <= 1'b1;
                    cnt              <= '0;
                    state            <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    cnt   <= cnt + 32'd1;
                    state <= S_WAIT_ACCEPT;
                end
                S_WAIT_ACCEPT: begin
                    // cnt counts cycles since activate rose, so the timeout
                    // fires after exactly ACCEPT_TMO cycles of activate.
                    if (bus.spi_busy) begin
                        bus.spi_activate <= 1'b0;
                        state            <= S_WAIT_DONE;
                    end else if (cnt >= 32'(ACCEPT_TMO - 1)) begin
                        bus.spi_activate <= 1'b0;
                        error            <= 1'b1;
                        init_done        <= 1'b1;
                        in_init          <= 1'b0;
                        state            <= S_READY;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.spi_busy) begin
                        if (in_init && idx == 2'd0) begin
                            cnt   <= '0;
                            state <= S_DELAY;
                        end else if (in_init && idx == 2'd1) begin
                            idx   <= 2'd2;
                            state <= S_LOAD;
                        end else begin
                            init_done <= 1'b1;
                            in_init   <= 1'b0;
                            state     <= S_READY;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt >= 32'(CLK_SWRESET - 1)) begin
                        idx   <= 2'd1;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_READY: begin
                    if (bus.req_valid) begin
                        if (len_ok) begin
                            lat_cs    <= bus.req_cs;
                            lat_bytes <= req_bytes;
                            lat_count <= bus.req_len + OUT_BYTES_SZ'(1);
                            in_init   <= 1'b0;
                            state     <= S_LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_POWERUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ht16d35a_cmd_sequencer.sv
module tb_ht16d35a_cmd_sequencer;

    localparam int P_POWERUP = 40;
    localparam int P_SWRESET = 20;
    localparam int P_TMO     = 16;

    logic clk;
    logic reset_n;
    logic init_done;
    logic error;

    ht16d35a_cmd_sequencer_if #(.NUM_SELECTS(2), .OUT_BYTES(8)) bus ();

    ht16d35a_cmd_sequencer #(
        .NUM_SELECTS (2),
        .OUT_BYTES   (8),
        .CLK_POWERUP (P_POWERUP),
        .CLK_SWRESET (P_SWRESET),
        .BRIGHTNESS  (8'h40),
        .ACCEPT_TMO  (P_TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.master),
        .init_done (init_done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected-transaction model.
    typedef struct {
        logic [1:0]      cs;
        logic [7:0][7:0] data;
        logic [2:0]      count;
    } txn_t;

    txn_t exp_q[$];

    function automatic txn_t make_req(input logic [1:0] cs, input logic [7:0] addr,
                                      input logic [5:0][7:0] pl, input int len);
        txn_t t;
        t.cs      = cs;
        t.data    = '0;
        t.data[0] = 8'h80;
        t.data[1] = addr;
        for (int i = 0; i < len; i++) t.data[2 + i] = pl[i];
        t.count   = 3'(len + 1);
        return t;
    endfunction

    function automatic txn_t make_init(input logic [7:0] b0, input logic [7:0] b1, input int cnt);
        txn_t t;
        t.cs      = 2'b11;
        t.data    = '0;
        t.data[0] = b0;
        t.data[1] = b1;
        t.count   = 3'(cnt);
        return t;
    endfunction

    // Controller busy model.
    logic busy_force;
    logic busy_model;
    logic no_accept;
    int   busy_delay;
    int   busy_len;
    logic err_allowed;

    assign bus.spi_busy = busy_force | busy_model;

    initial begin
        int phase;
        int k;
        busy_model = 1'b0;
        phase = 0;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                busy_model = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (bus.spi_activate && !no_accept) begin
                        phase = 1;
                        k = 1;
                    end
                    1: if (k >= busy_delay) begin
                        busy_model = 1'b1;
                        phase = 2;
                        k = 0;
                    end else k++;
                    2: begin
                        k++;
                        if (k >= busy_len) begin
                            busy_model = 1'b0;
                            phase = 3;
                        end
                    end
                    default: if (!bus.spi_activate) phase = 0;
                endcase
            end
        end
    end

    // Compare process: sampled 1 time unit after every falling edge.
    int cyc = 0;
    initial begin
        logic            prev_act, prev_busy, in_txn, pend_first, after_cc;
        int              rel_cyc, rise_cyc, busy_seen, fall_cyc;
        logic [1:0]      cur_cs;
        logic [7:0][7:0] cur_data;
        logic [2:0]      cur_count;
        txn_t            t;
        prev_act = 0; prev_busy = 0; in_txn = 0; pend_first = 1; after_cc = 0;
        rel_cyc = 0; rise_cyc = 0; busy_seen = -1; fall_cyc = 0;
        cur_cs = '0; cur_data = '0; cur_count = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                check("rst_activate", 64'(bus.spi_activate), 64'd0);
                check("rst_out_data", bus.spi_out_data, 64'd0);
                check("rst_out_count", 64'(bus.spi_out_count), 64'd0);
                check("rst_in_cs", 64'(bus.spi_in_cs), 64'd0);
                check("rst_init_done", 64'(init_done), 64'd0);
                check("rst_error", 64'(error), 64'd0);
                check("rst_req_ready", 64'(bus.req_ready), 64'd0);
                exp_q.delete();
                exp_q.push_back(make_init(8'hCC, 8'h00, 0));
                exp_q.push_back(make_init(8'h35, 8'h03, 1));
                exp_q.push_back(make_init(8'h37, 8'h40, 1));
                prev_act = 0; prev_busy = 0; in_txn = 0; pend_first = 1; after_cc = 0;
                busy_seen = -1; rel_cyc = cyc;
            end else begin
                if (!err_allowed) check("error_clear", 64'(error), 64'd0);
                if (bus.spi_activate && !prev_act) begin
                    if (pend_first)
                        check("powerup_wait", 64'(cyc - rel_cyc >= P_POWERUP), 64'd1);
                    if (after_cc)
                        check("swreset_gap", 64'(cyc - fall_cyc >= P_SWRESET), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_activate: got activate expected none at %0t", $time);
                    end else begin
                        t = exp_q.pop_front();
                        check("txn_in_cs", 64'(bus.spi_in_cs), 64'(t.cs));
                        check("txn_out_data", bus.spi_out_data, t.data);
                        check("txn_out_count", 64'(bus.spi_out_count), 64'(t.count));
                    end
                    cur_cs = bus.spi_in_cs;
                    cur_data = bus.spi_out_data;
                    cur_count = bus.spi_out_count;
                    in_txn = 1; rise_cyc = cyc; busy_seen = -1;
                    pend_first = 0; after_cc = 0;
                end
                if (bus.spi_activate && bus.spi_busy && busy_seen < 0) busy_seen = cyc;
                if (!bus.spi_activate && prev_act) begin
                    if (busy_seen >= 0) check("activate_hold", 64'(cyc), 64'(busy_seen + 1));
                    else check("activate_timeout_len", 64'(cyc - rise_cyc), 64'(P_TMO));
                end
                if (in_txn) begin
                    if (bus.spi_activate || bus.spi_busy) begin
                        check("hold_data", bus.spi_out_data, cur_data);
                        check("hold_cs_count", 64'({bus.spi_in_cs, bus.spi_out_count}),
                              64'({cur_cs, cur_count}));
                    end else begin
                        in_txn = 0;
                        if (prev_busy) begin
                            fall_cyc = cyc;
                            after_cc = (cur_data[0] == 8'hCC);
                        end
                    end
                end
                prev_act = bus.spi_activate;
                prev_busy = bus.spi_busy;
            end
        end
    end

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_init_done"}, 64'(init_done), 64'd1);
        #1;
        check({nm, "_init_all_sent"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_ready_after_init"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic send_req(input logic [1:0] cs, input logic [7:0] addr,
                            input logic [47:0] pl, input logic [2:0] len);
        int n;
        @(negedge clk);
        bus.req_cs = cs;
        bus.req_addr = addr;
        bus.req_data = pl;
        bus.req_len = len;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_wait", 64'(bus.req_ready), 64'd1);
        if (len >= 3'd1 && len <= 3'd6) exp_q.push_back(make_req(cs, addr, pl, int'(len)));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Called right after send_req returns: checks the two-cycle activate latency.
    task automatic check_latency(input string nm);
        @(negedge clk);
        #1;
        check({nm, "_lat_cyc1_act"}, 64'(bus.spi_activate), 64'd0);
        check({nm, "_lat_cyc1_ready"}, 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        #1;
        check({nm, "_lat_cyc2_act"}, 64'(bus.spi_activate), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((bus.spi_activate || bus.spi_busy) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, "_idle"}, 64'(bus.spi_activate | bus.spi_busy), 64'd0);
        @(negedge clk);
        #1;
        check({nm, "_ready_back"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        err_allowed = 1'b0;
        busy_force = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        busy_force = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        busy_force = 1'b1;
        no_accept = 1'b0;
        busy_delay = 9;
        busy_len = 5;
        err_allowed = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cs = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_len = '0;
        // Host request raised before init: must be held off, not consumed.
        bus.req_valid = 1'b1;
        bus.req_len = 3'd0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;

        // Busy held past the power-up count: no activate may start.
        repeat (60) @(negedge clk);
        #1;
        check("busy_holdoff_act", 64'(bus.spi_activate), 64'd0);
        check("pre_init_ready", 64'(bus.req_ready), 64'd0);
        busy_force = 1'b0;
        wait_init("boot");
        bus.req_valid = 1'b0;

        // Request A: pinned literal frame.
        busy_delay = 9;
        busy_len = 6;
        send_req(2'b01, 8'h10, 48'h0000_0000_55AA, 3'd2);
        check_latency("reqA");
        check("reqA_data_lit", bus.spi_out_data, 64'h0000_0000_55AA_1080);
        check("reqA_count_lit", 64'(bus.spi_out_count), 64'd3);
        check("reqA_cs_lit", 64'(bus.spi_in_cs), 64'h1);
        n = 0;
        while (!bus.spi_busy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        while (bus.spi_busy && n < 200) begin
            check("reqA_ready_while_busy", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
            #1;
            n++;
        end
        check("reqA_ready_at_busy_fall", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        #1;
        check("reqA_ready_after", 64'(bus.req_ready), 64'd1);

        // Request B: full payload, fast accept.
        busy_delay = 1;
        busy_len = 4;
        send_req(2'b10, 8'h20, 48'h6655_4433_2211, 3'd6);
        check_latency("reqB");
        wait_idle("reqB");

        // Request C: single byte, stale upper payload must not leak.
        busy_delay = 3;
        send_req(2'b11, 8'hFF, 48'hDEAD_BEEF_C35A, 3'd1);
        check_latency("reqC");
        check("reqC_data_lit", bus.spi_out_data, 64'h0000_0000_005A_FF80);
        check("reqC_count_lit", 64'(bus.spi_out_count), 64'd2);
        wait_idle("reqC");

        // Illegal length 0.
        err_allowed = 1'b1;
        send_req(2'b01, 8'h00, 48'h0, 3'd0);
        @(negedge clk);
        #1;
        check("len0_error", 64'(error), 64'd1);
        check("len0_ready", 64'(bus.req_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            #1;
            check("len0_no_activate", 64'(bus.spi_activate), 64'd0);
        end

        // Illegal length 7 from a clean error flag.
        do_reset();
        wait_init("rst2");
        check("rst2_error", 64'(error), 64'd0);
        err_allowed = 1'b1;
        send_req(2'b10, 8'h44, 48'h0102_0304_0506, 3'd7);
        @(negedge clk);
        #1;
        check("len7_error", 64'(error), 64'd1);
        check("len7_ready", 64'(bus.req_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            #1;
            check("len7_no_activate", 64'(bus.spi_activate), 64'd0);
        end

        // Accept timeout.
        do_reset();
        wait_init("rst3");
        err_allowed = 1'b1;
        no_accept = 1'b1;
        send_req(2'b01, 8'h30, 48'h0000_0000_0077, 3'd1);
        check_latency("tmo");
        n = 0;
        while (bus.spi_activate && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("tmo_activate_dropped", 64'(bus.spi_activate), 64'd0);
        check("tmo_error", 64'(error), 64'd1);
        check("tmo_ready", 64'(bus.req_ready), 64'd1);
        check("tmo_init_done", 64'(init_done), 64'd1);
        no_accept = 1'b0;

        // Reset during S_WAIT_DONE.
        do_reset();
        wait_init("rst4");
        busy_delay = 2;
        busy_len = 30;
        send_req(2'b11, 8'h55, 48'h0000_0000_3344, 3'd2);
        n = 0;
        while (!(bus.spi_busy && !bus.spi_activate) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_in_wait_done", 64'(bus.spi_busy & ~bus.spi_activate), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_activate", 64'(bus.spi_activate), 64'd0);
        check("mid_rst_data", bus.spi_out_data, 64'd0);
        check("mid_rst_init_done", 64'(init_done), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_init("replay");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
